fifo_readout_scheduler: RTL and testbench
=========================================

Name: fifo_readout_scheduler

Overview:
Round-robin scheduler that shares the single pixel readout path between NUM_BANKS column-bank FIFOs.
- Each bank raises a "columns ready" flag when a full column block is buffered.
- The scheduler grants one bank at a time and drives a burst of exactly BURST_LEN read enables to that bank's FIFO.
- Reads pause while the downstream sink deasserts out_ready.
- Sits between the column-bank write side and the serializer/USB packer.

Parameters:
NUM_BANKS, 4, number of requesting column-bank FIFOs (2..8)
BURST_LEN, 552, reads issued per granted burst (138 cols x 4 words); must be >= 1
CNT_W, 10, burst counter width; must satisfy 2^CNT_W > BURST_LEN
GAP_CYCLES, 2, idle cycles inserted after each burst before the next grant (0 allowed)

Ports:
fifo_rd_clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
sched_en  in  1  1 = new bursts may start; 0 = finish current burst, then hold in IDLE
bank_flag  in  NUM_BANKS  per-bank ready flag from the write side (level, synchronous to fifo_rd_clk)
out_ready  in  1  downstream can accept a word this cycle
fifo_rd_en  out  NUM_BANKS  one-hot read enable to the granted bank FIFO
grant_id  out  3  index of the granted bank (valid while busy)
busy  out  1  high in the BURST and GAP states
burst_done  out  1  one-cycle pulse after the last read of a burst
overrun  out  NUM_BANKS  sticky per-bank overrun flag (only with OVERRUN_DETECT_EN)

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; pending = 0; flag_d = 0; count = 0; last_grant = NUM_BANKS-1, so bank 0 has priority first.
  - All outputs 0.
  - Reset asserted mid-burst drops fifo_rd_en immediately (combinational path through state).
- Request capture:
  - flag_d registers bank_flag.
  - A rising edge (bank_flag & ~flag_d) sets pending[i].
  - A level held high does not re-request.
- State machine:
  - IDLE: if sched_en=1 and pending != 0:
    - pick the first pending bank searching from last_grant+1 upward, wrapping modulo NUM_BANKS;
    - latch it into grant_id and last_grant; clear its pending bit; load count = BURST_LEN; go to BURST.
    - Otherwise stay in IDLE.
  - BURST:
    - fifo_rd_en[grant_id] = out_ready; all other bits 0.
    - Each cycle with out_ready=1: count decrements.
    - When count==1 and out_ready=1 (last read): next state is GAP, or IDLE if GAP_CYCLES=0; burst_done=1 on the following cycle.
    - out_ready=0: count holds and no read is issued; there is no timeout.
    - sched_en=0 does not abort BURST.
  - GAP: count loaded with GAP_CYCLES on entry; decrements each cycle; at 1 go to IDLE. fifo_rd_en = 0.
- Simultaneous events:
  - A new edge on the bank being cleared in the same cycle: the set wins and pending stays 1.
  - Edges on other banks during BURST or GAP are queued in pending; there is no loss.
- Latency:
  - Flag edge to first fifo_rd_en = 2 cycles from IDLE: 1 for edge register, 1 for grant.
  - Exactly BURST_LEN enables per grant, regardless of stalls.
- grant_id holds its last value in IDLE; busy = 0 in IDLE.

Optional Feature:
OVERRUN_DETECT_EN:
- Defined: an edge on bank i while pending[i]=1 (not being cleared that cycle), or while bank i is granted in BURST, sets overrun[i].
  - overrun[i] is sticky until rst_n.
  - The request itself is merged (a single pending bit).
- Undefined: the overrun port is tied to 0 and no detection logic is built; duplicate edges merge silently.

Test Plan:
1. Reset, then a bank_flag[0] edge with out_ready=1 -> fifo_rd_en=4'b0001 starting 2 cycles later for exactly 552 consecutive cycles; burst_done pulses once; busy low after 2 gap cycles.
2. Edges on banks 1, 3 and 0 in the same cycle after reset -> bursts serviced in order 0, 1, 3; each burst has 552 enables; grant_id sequence is 0, 1, 3.
3. out_ready toggled 1-0 every cycle during a burst -> 552 enables spread over 1103 cycles; count never decrements on stall cycles.
4. sched_en=0 while bank 2 is pending -> no grant; set sched_en=1 -> burst starts 1 cycle later. Drop sched_en mid-burst -> the burst completes all 552 reads.
5. rst_n asserted at read 300 -> fifo_rd_en=0 in the same cycle. After release with no new edges -> no burst.
6. With OVERRUN_DETECT_EN, a second bank_flag[1] edge during bank 1's burst -> overrun=4'b0010 and exactly one extra burst for bank 1. Without the macro, overrun stays 0.

Source files
------------

// File: rtl/fifo_readout_scheduler.sv
// Round-robin readout scheduler sharing one pixel path between column-bank FIFOs.
// Optional sticky overrun detection is built when OVERRUN_DETECT_EN is defined.
module fifo_readout_scheduler #(
  parameter int NUM_BANKS  = 4,
  parameter int BURST_LEN  = 552,
  parameter int CNT_W      = 10,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 fifo_rd_clk,
  input  logic                 rst_n,
  input  logic                 sched_en,
  input  logic [NUM_BANKS-1:0] bank_flag,
  input  logic                 out_ready,
  output logic [NUM_BANKS-1:0] fifo_rd_en,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 burst_done,
  output logic [NUM_BANKS-1:0] overrun
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [NUM_BANKS-1:0] flag_d;
  logic [NUM_BANKS-1:0] pending;
  logic [NUM_BANKS-1:0] pending_nx;
  logic [NUM_BANKS-1:0] rise;
  logic [NUM_BANKS-1:0] clr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nx;
  logic [2:0]           last_grant;
  logic [2:0]           pick;
  logic                 pick_vld;
  logic                 go;
  logic                 last_rd;
  logic                 done_q;

  assign rise       = bank_flag & ~flag_d;
  assign busy       = (state != IDLE);
  assign burst_done = done_q;

  // Round-robin search: nearest pending bank after last_grant, wrapping.
  always_comb begin
    int best_d;
    int d;
    best_d   = NUM_BANKS;
    d        = 0;
    pick     = '0;
    pick_vld = |pending;
    for (int i = 0; i < NUM_BANKS; i++) begin
      d = (i + 2 * NUM_BANKS - int'(last_grant) - 1) % NUM_BANKS;
      if (pending[i] && d < best_d) begin
        best_d = d;
        pick   = 3'(i);
      end
    end
  end

  // Next state, counter update and grant/last-read strobes.
  always_comb begin
    state_nx = state;
    count_nx = count;
    go       = 1'b0;
    last_rd  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sched_en && pick_vld) begin
          go       = 1'b1;
          count_nx = CNT_W'(BURST_LEN);
          state_nx = BURST;
        end
      end
      BURST: begin
        if (out_ready) begin
          count_nx = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            last_rd = 1'b1;
            if (GAP_CYCLES == 0) begin
              state_nx = IDLE;
            end else begin
              count_nx = CNT_W'(GAP_CYCLES);
              state_nx = GAP;
            end
          end
        end
      end
      GAP: begin
        count_nx = count - CNT_W'(1);
        if (count <= CNT_W'(1)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pending-bit clear for the granted bank; a coincident edge re-sets it.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      clr[i] = go && (pick == 3'(i));
    end
    pending_nx = (pending & ~clr) | rise;
  end

  // One-hot read enable, only while bursting and the sink accepts.
  always_comb begin
    fifo_rd_en = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      fifo_rd_en[i] = (state == BURST) && out_ready
                      && (grant_id == 3'(i));
    end
  end

  // State, counter, request capture and grant registers.
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      flag_d     <= '0;
      pending    <= '0;
      last_grant <= 3'(NUM_BANKS - 1);
      grant_id   <= '0;
      done_q     <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      flag_d  <= bank_flag;
      pending <= pending_nx;
      done_q  <= last_rd;
      if (go) begin
        last_grant <= pick;
        grant_id   <= pick;
      end
    end
  end

`ifdef OVERRUN_DETECT_EN
  logic [NUM_BANKS-1:0] ovr_set;
  logic [NUM_BANKS-1:0] ovr_q;

  // Duplicate edge: still pending, or arriving during its own burst.
  always_comb begin
    ovr_set = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      ovr_set[i] = rise[i] && ((pending[i] && !clr[i])
                   || ((state == BURST) && (grant_id == 3'(i))));
    end
  end

  // Sticky overrun flags, cleared only by reset.
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_q | ovr_set;
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = '0;
`endif

endmodule

// File: tb/tb_fifo_readout_scheduler.sv
// Directed self-checking bench for fifo_readout_scheduler.
// Covers reset, latency, round-robin order, stalls, sched_en, reset abort, overrun.
module tb_fifo_readout_scheduler;

  localparam int NB = 4;
  localparam int BL = 552;

  logic          clk;
  logic          rst_n;
  logic          sched_en;
  logic [NB-1:0] bank_flag;
  logic          out_ready;
  logic [NB-1:0] fifo_rd_en;
  logic [2:0]    grant_id;
  logic          busy;
  logic          burst_done;
  logic [NB-1:0] overrun;

  int checks;
  int errors;
  int en_cnt [NB];
  int done_cnt;
  int order[$];
  logic busy_prev;
  logic bad_hot;

  fifo_readout_scheduler dut (
    .fifo_rd_clk(clk),
    .rst_n(rst_n),
    .sched_en(sched_en),
    .bank_flag(bank_flag),
    .out_ready(out_ready),
    .fifo_rd_en(fifo_rd_en),
    .grant_id(grant_id),
    .busy(busy),
    .burst_done(burst_done),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cycle monitor: read enables, done pulses, grant order.
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (fifo_rd_en[i]) en_cnt[i]++;
    end
    if ($countones(fifo_rd_en) > 1) bad_hot = 1'b1;
    if (burst_done) done_cnt++;
    if (busy && !busy_prev) order.push_back(int'(grant_id));
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    for (int i = 0; i < NB; i++) en_cnt[i] = 0;
    done_cnt = 0;
    order.delete();
    bad_hot = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bank_flag = '0;
    sched_en  = 1'b1;
    out_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clr_mon();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    busy_prev = 1'b0;
    bad_hot   = 1'b0;
    done_cnt  = 0;
    for (int i = 0; i < NB; i++) en_cnt[i] = 0;
    rst_n     = 1'b0;
    sched_en  = 1'b0;
    bank_flag = '0;
    out_ready = 1'b0;
    tick(2);

    // Reset state
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(burst_done), 0);
    chk("rst_ovr", 32'(overrun), 0);

    // 1: single bank 0 burst, latency and gap
    do_reset();
    bank_flag = 4'b0001;
    tick(1);
    chk("t1_lat1", 32'(fifo_rd_en), 0);
    tick(1);
    chk("t1_first", 32'(fifo_rd_en), 32'h1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_gid", 32'(grant_id), 0);
    tick(BL - 1);
    chk("t1_lastrd", 32'(fifo_rd_en), 32'h1);
    tick(1);
    chk("t1_endrd", 32'(fifo_rd_en), 0);
    chk("t1_done", 32'(burst_done), 1);
    chk("t1_gap1", 32'(busy), 1);
    tick(1);
    chk("t1_done0", 32'(burst_done), 0);
    chk("t1_gap2", 32'(busy), 1);
    tick(1);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_cnt", 32'(en_cnt[0]), BL);
    chk("t1_ndone", 32'(done_cnt), 1);
    tick(20);
    chk("t1_norereq", 32'(en_cnt[0]), BL);
    bank_flag = '0;

    // 2: simultaneous edges on 1, 3, 0 -> order 0, 1, 3
    do_reset();
    bank_flag = 4'b1011;
    tick(1800);
    chk("t2_nord", 32'(order.size()), 3);
    if (order.size() == 3) begin
      chk("t2_ord0", 32'(order[0]), 0);
      chk("t2_ord1", 32'(order[1]), 1);
      chk("t2_ord2", 32'(order[2]), 3);
    end
    chk("t2_cnt0", 32'(en_cnt[0]), BL);
    chk("t2_cnt1", 32'(en_cnt[1]), BL);
    chk("t2_cnt3", 32'(en_cnt[3]), BL);
    chk("t2_cnt2", 32'(en_cnt[2]), 0);
    chk("t2_ndone", 32'(done_cnt), 3);
    chk("t2_busy", 32'(busy), 0);
    bank_flag = '0;

    // 3: out_ready toggling 1/0 -> 552 reads over 1103 cycles
    do_reset();
    bank_flag = 4'b0100;
    tick(2);
    for (int i = 0; i < 2 * BL - 1; i++) begin
      out_ready = (i % 2 == 0);
      if (i == 1) begin
        #1;
        chk("t3_stall_en", 32'(fifo_rd_en), 0);
      end
      tick(1);
      if (i == 2 * BL - 3) begin
        chk("t3_cnt_pre", 32'(en_cnt[2]), BL - 1);
        chk("t3_busy_pre", 32'(busy), 1);
        chk("t3_done_pre", 32'(burst_done), 0);
      end
    end
    chk("t3_done", 32'(burst_done), 1);
    chk("t3_cnt", 32'(en_cnt[2]), BL);
    out_ready = 1'b1;
    bank_flag = '0;
    tick(5);

    // 4: sched_en gating and mid-burst drop
    do_reset();
    sched_en  = 1'b0;
    bank_flag = 4'b0100;
    tick(6);
    chk("t4_hold_busy", 32'(busy), 0);
    chk("t4_hold_en", 32'(fifo_rd_en), 0);
    sched_en = 1'b1;
    tick(1);
    chk("t4_start", 32'(fifo_rd_en), 32'h4);
    tick(10);
    sched_en  = 1'b0;
    bank_flag = 4'b0101;
    tick(600);
    chk("t4_cnt2", 32'(en_cnt[2]), BL);
    chk("t4_cnt0", 32'(en_cnt[0]), 0);
    chk("t4_ndone", 32'(done_cnt), 1);
    chk("t4_idle", 32'(busy), 0);
    bank_flag = '0;
    sched_en  = 1'b1;

    // 5: reset mid-burst at read 300
    do_reset();
    bank_flag = 4'b1000;
    tick(2);
    bank_flag = '0;
    tick(299);
    chk("t5_pre", 32'(fifo_rd_en), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("t5_drop", 32'(fifo_rd_en), 0);
    chk("t5_busy", 32'(busy), 0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("t5_noburst", 32'(busy), 0);
    chk("t5_cnt", 32'(en_cnt[3]), 299);

    // 6: second bank 1 edge during its own burst
    do_reset();
    bank_flag = 4'b0010;
    tick(3);
    bank_flag = '0;
    tick(50);
    bank_flag = 4'b0010;
    tick(2);
    bank_flag = '0;
    tick(1200);
    chk("t6_cnt", 32'(en_cnt[1]), 2 * BL);
    chk("t6_ndone", 32'(done_cnt), 2);
`ifdef OVERRUN_DETECT_EN
    chk("t6_ovr", 32'(overrun), 32'h2);
`else
    chk("t6_ovr", 32'(overrun), 0);
`endif

    chk("onehot", 32'(bad_hot), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
